// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI write path: shift-register op codes and FSM state encoding.
// Used by dac_spi_ctrl and by the PISO shift register's testbench.
package dac_spi_pkg;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_LDAC  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_SETUP = ST_SETUP,
        S_SHIFT = ST_SHIFT,
        S_HOLD  = ST_HOLD,
        S_LDAC  = ST_LDAC,
        S_DONE  = ST_DONE
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period counter: counts 0..ClkDiv-1 while enabled, held at 0 otherwise, ticks at ClkDiv-1.
// o_tick_next gives the tick of the following cycle for consumers that register their outputs.
module sclk_tick_gen
    import dac_spi_pkg::*;
#(
    parameter int ClkDiv = 4
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_en,
    output logic o_tick,
    output logic o_tick_next
);

    localparam int CW = cnt_width(ClkDiv);
    localparam logic [CW-1:0] CNT_MAX = CW'(ClkDiv - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_tick;

    always_comb begin
        w_cnt_next = '0;
        if (i_en && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    assign o_tick_next = (w_cnt_next == CNT_MAX);
    assign o_tick      = r_tick;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_cnt  <= '0;
            r_tick <= (CNT_MAX == '0);
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= o_tick_next;
        end
    end

endmodule

// File: rtl/dac_spi_ctrl.sv
// DAC serial write sequencer: drives PISO op codes plus cs_n/sclk framing, MSB first.
// Optional LDAC strobe state enabled by defining DAC_SPI_CTRL_LDAC_EN.
module dac_spi_ctrl
    import dac_spi_pkg::*;
#(
    parameter int Width   = 16,
    parameter int ClkDiv  = 4,
    parameter int CsSetup = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [1:0] op_o,
    output logic       sclk_o,
`ifdef DAC_SPI_CTRL_LDAC_EN
    output logic       ldac_n_o,
`endif
    output logic       cs_n_o
);

    localparam int BW = cnt_width(Width);
    localparam int SW = cnt_width(CsSetup);
    localparam logic [BW-1:0] BIT_LAST = BW'(Width - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(CsSetup - 1);

    state_t        r_state, w_state_next;
    logic [BW-1:0] r_bit_cnt, w_bit_cnt_next;
    logic [SW-1:0] r_set_cnt, w_set_cnt_next;
    logic          r_phase, w_phase_next;
    logic          w_tick, w_tick_next, w_tick_en;
    logic [1:0]    r_op, w_op_next;
    logic          r_sclk, r_cs_n, r_busy, r_done;

`ifdef DAC_SPI_CTRL_LDAC_EN
    logic r_ldac_n;
    assign w_tick_en = (r_state == S_SHIFT) || (r_state == S_LDAC);
    assign ldac_n_o  = r_ldac_n;
`else
    assign w_tick_en = (r_state == S_SHIFT);
`endif

    sclk_tick_gen #(.ClkDiv(ClkDiv)) u_tick (
        .i_clk       (clk_i),
        .i_srst      (rst_i),
        .i_en        (w_tick_en),
        .o_tick      (w_tick),
        .o_tick_next (w_tick_next)
    );

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_set_cnt_next = r_set_cnt;
        w_phase_next   = r_phase;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = S_LOAD;
            S_LOAD: begin
                w_state_next   = S_SETUP;
                w_set_cnt_next = '0;
            end
            S_SETUP: begin
                if (r_set_cnt == SET_LAST) begin
                    w_state_next   = S_SHIFT;
                    w_set_cnt_next = '0;
                    w_bit_cnt_next = '0;
                    w_phase_next   = 1'b0;
                end else begin
                    w_set_cnt_next = r_set_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_tick) begin
                    // phase 0 = sclk low half, phase 1 = sclk high half
                    w_phase_next = ~r_phase;
                    if (r_phase) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_next   = S_HOLD;
                            w_bit_cnt_next = '0;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (r_set_cnt == SET_LAST) begin
                    w_set_cnt_next = '0;
`ifdef DAC_SPI_CTRL_LDAC_EN
                    w_state_next   = S_LDAC;
`else
                    w_state_next   = S_DONE;
`endif
                end else begin
                    w_set_cnt_next = r_set_cnt + 1'b1;
                end
            end
            S_LDAC:  if (w_tick) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_op_next = OP_HOLD;
        case (w_state_next)
            S_LOAD:  w_op_next = OP_LOAD;
            S_DONE:  w_op_next = OP_CLR;
            S_SHIFT: if (w_phase_next && w_tick_next && (w_bit_cnt_next != BIT_LAST))
                         w_op_next = OP_SHIFT;
            default: w_op_next = OP_HOLD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_set_cnt <= '0;
            r_phase   <= 1'b0;
            r_op      <= OP_HOLD;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef DAC_SPI_CTRL_LDAC_EN
            r_ldac_n  <= 1'b1;
`endif
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_set_cnt <= w_set_cnt_next;
            r_phase   <= w_phase_next;
            r_op      <= w_op_next;
            r_sclk    <= (w_state_next == S_SHIFT) && w_phase_next;
            r_cs_n    <= !((w_state_next == S_SETUP) || (w_state_next == S_SHIFT) ||
                           (w_state_next == S_HOLD));
            r_busy    <= (w_state_next != S_IDLE);
            r_done    <= (w_state_next == S_DONE);
`ifdef DAC_SPI_CTRL_LDAC_EN
            r_ldac_n  <= (w_state_next != S_LDAC);
`endif
        end
    end

    assign op_o   = r_op;
    assign sclk_o = r_sclk;
    assign cs_n_o = r_cs_n;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Bench for dac_spi_ctrl: default instance (16/4/2) and a small one (8/1/1), both checked every
// cycle against a frame-offset reference model, with a behavioural PISO recovering the data word.
module tb_dac_spi_ctrl;
    import dac_spi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [2];
    logic       start_s [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       sclk_w  [2];
    logic       cs_n_w  [2];
    logic [1:0] op_w    [2];
`ifdef DAC_SPI_CTRL_LDAC_EN
    logic       ldac_w  [2];
    localparam bit LdacEn = 1'b1;
`else
    localparam bit LdacEn = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    int cd_p [2] = '{4, 1};
    int cs_p [2] = '{2, 1};
    int w_p  [2] = '{16, 8};

    bit          m_active  [2];
    int          m_k       [2];
    int          frames    [2];
    logic [31:0] din       [2];
    logic [31:0] sr        [2];
    logic [31:0] rx        [2];
    int          rises     [2];
    logic [1:0]  prev_op   [2];
    logic        prev_sclk [2];

    dac_spi_ctrl #(.Width(16), .ClkDiv(4), .CsSetup(2)) u_dut0 (
        .clk_i   (clk),
        .rst_i   (rst_s[0]),
        .start_i (start_s[0]),
        .busy_o  (busy_w[0]),
        .done_o  (done_w[0]),
        .op_o    (op_w[0]),
        .sclk_o  (sclk_w[0]),
`ifdef DAC_SPI_CTRL_LDAC_EN
        .ldac_n_o(ldac_w[0]),
`endif
        .cs_n_o  (cs_n_w[0])
    );

    dac_spi_ctrl #(.Width(8), .ClkDiv(1), .CsSetup(1)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst_s[1]),
        .start_i (start_s[1]),
        .busy_o  (busy_w[1]),
        .done_o  (done_w[1]),
        .op_o    (op_w[1]),
        .sclk_o  (sclk_w[1]),
`ifdef DAC_SPI_CTRL_LDAC_EN
        .ldac_n_o(ldac_w[1]),
`endif
        .cs_n_o  (cs_n_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int d);
        return (32'h1 << w_p[d]) - 32'h1;
    endfunction

    function automatic int frame_len(input int d);
        return 1 + cs_p[d] + 2 * cd_p[d] * w_p[d] + cs_p[d] + (LdacEn ? cd_p[d] : 0) + 1;
    endfunction

    // Expected {ldac_n, busy, done, cs_n, sclk, op} from the cycle offset inside the frame.
    function automatic logic [6:0] exp_out(input int d);
        int cd = cd_p[d];
        int cs = cs_p[d];
        int w  = w_p[d];
        int k  = m_k[d];
        int sh = 2 * cd * w;
        int ldl = LdacEn ? cd : 0;
        int j;
        logic [1:0] op = OP_HOLD;
        logic sclk = 1'b0, cs_n = 1'b1, busy = 1'b0, done = 1'b0, ldac_n = 1'b1;
        if (m_active[d]) begin
            busy = 1'b1;
            if (k == 0) begin
                op = OP_LOAD;
            end else if (k <= cs) begin
                cs_n = 1'b0;
            end else if (k <= cs + sh) begin
                cs_n = 1'b0;
                j = k - cs - 1;
                sclk = ((j % (2 * cd)) >= cd);
                if (((j % (2 * cd)) == 2 * cd - 1) && ((j / (2 * cd)) < w - 1)) op = OP_SHIFT;
            end else if (k <= 2 * cs + sh) begin
                cs_n = 1'b0;
            end else if (k <= 2 * cs + sh + ldl) begin
                ldac_n = 1'b0;
            end else begin
                done = 1'b1;
                op   = OP_CLR;
            end
        end
        return {ldac_n, busy, done, cs_n, sclk, op};
    endfunction

    task automatic model_edge(input int d);
        if (rst_s[d]) begin
            m_active[d] = 1'b0;
            m_k[d]      = 0;
        end else if (!m_active[d]) begin
            if (start_s[d]) begin
                m_active[d] = 1'b1;
                m_k[d]      = 0;
                din[d] = (d == 0 && frames[0] == 0) ? 32'h0000_A5C3 : ($urandom & wmask(d));
            end
        end else if (m_k[d] == frame_len(d) - 1) begin
            m_active[d] = 1'b0;
        end else begin
            m_k[d]++;
        end
    endtask

    task automatic check_dut(input int d);
        logic [6:0] e = exp_out(d);
        check($sformatf("op%0d", d),   {30'd0, op_w[d]}, {30'd0, e[1:0]});
        check($sformatf("sclk%0d", d), {31'd0, sclk_w[d]}, {31'd0, e[2]});
        check($sformatf("cs_n%0d", d), {31'd0, cs_n_w[d]}, {31'd0, e[3]});
        check($sformatf("done%0d", d), {31'd0, done_w[d]}, {31'd0, e[4]});
        check($sformatf("busy%0d", d), {31'd0, busy_w[d]}, {31'd0, e[5]});
`ifdef DAC_SPI_CTRL_LDAC_EN
        check($sformatf("ldac%0d", d), {31'd0, ldac_w[d]}, {31'd0, e[6]});
`endif
        // downstream PISO acts on the op it saw during the previous cycle
        case (prev_op[d])
            OP_LOAD:  sr[d] = din[d];
            OP_SHIFT: sr[d] = (sr[d] << 1) & wmask(d);
            OP_CLR:   sr[d] = 32'h0;
            default:  ;
        endcase
        if (sclk_w[d] === 1'b1 && prev_sclk[d] === 1'b0) begin
            rx[d] = ((rx[d] << 1) | {31'd0, sr[d][w_p[d] - 1]}) & wmask(d);
            rises[d]++;
        end
        if (op_w[d] === OP_LOAD) begin
            rx[d]    = 32'h0;
            rises[d] = 0;
        end
        if (m_active[d] && m_k[d] == frame_len(d) - 1) begin
            check($sformatf("data%0d", d), rx[d], din[d]);
            check($sformatf("rises%0d", d), rises[d], w_p[d]);
            $display("dut%0d frame %0d: sent 0x%0h received 0x%0h rises=%0d", d, frames[d], din[d],
                     rx[d], rises[d]);
            frames[d]++;
        end
        prev_op[d]   = op_w[d];
        prev_sclk[d] = sclk_w[d];
    endtask

    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        #1;
        for (int d = 0; d < 2; d++) check_dut(d);
    endtask

    initial begin
        int n;
        int target;
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1;  start_s[d] = 1'b0;
            m_active[d] = 1'b0; m_k[d] = 0; frames[d] = 0;
            din[d] = 32'h0; sr[d] = 32'h0; rx[d] = 32'h0; rises[d] = 0;
            prev_op[d] = OP_HOLD; prev_sclk[d] = 1'b0;
        end
        repeat (3) step();
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        step();

        // single frame on each instance
        start_s[0] = 1'b1; step(); start_s[0] = 1'b0;
        repeat (140) step();
        start_s[1] = 1'b1; step(); start_s[1] = 1'b0;
        repeat (30) step();

        // start held high: back-to-back frames
        start_s[0] = 1'b1; start_s[1] = 1'b1;
        repeat (400) step();
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        repeat (140) step();

        // reset during bit 7, then a fresh frame
        start_s[0] = 1'b1; step(); start_s[0] = 1'b0;
        target = 1 + cs_p[0] + 7 * 2 * cd_p[0] + 1;
        n = 0;
        while (!(m_active[0] && m_k[0] == target) && n < 300) begin
            step();
            n++;
        end
        check("reach_bit7", {31'd0, (n < 300)}, 32'd1);
        rst_s[0] = 1'b1; step(); rst_s[0] = 1'b0;
        repeat (5) step();
        start_s[0] = 1'b1; step(); start_s[0] = 1'b0;
        repeat (140) step();

        // randomized starts with occasional resets
        repeat (1500) begin
            for (int d = 0; d < 2; d++) begin
                start_s[d] = ($urandom_range(0, 3) == 0);
                rst_s[d]   = ($urandom_range(0, 299) == 0);
            end
            step();
        end
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            rst_s[d]   = 1'b0;
        end
        repeat (150) step();

        check("frames0_seen", {31'd0, (frames[0] >= 6)}, 32'd1);
        check("frames1_seen", {31'd0, (frames[1] >= 6)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
